// File: rtl/axi_slice_iso.sv
// axi_slice_iso: AXI4 register slice with per-channel FIFOs, outstanding limits and drain-then-isolate control.
// AXI ports are flattened: s_* faces the upstream master, m_* faces the downstream slave.
module axi_slice_iso_fifo #(
    parameter int W     = 1,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic [CW-1:0] cnt;
    assign full  = cnt == CW'(DEPTH);
    assign empty = cnt == '0;
    assign rdata = mem[rptr];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) wptr <= wptr == PW'(DEPTH - 1) ? '0 : wptr + 1'b1;
            if (pop) rptr <= rptr == PW'(DEPTH - 1) ? '0 : rptr + 1'b1;
            if (push != pop) cnt <= push ? cnt + 1'b1 : cnt - 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wdata;
    end
endmodule

module axi_slice_iso #(
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int AXI_DATA_WIDTH  = 64,
    parameter int AXI_USER_WIDTH  = 6,
    parameter int AXI_ID_WIDTH    = 6,
    parameter int AW_DEPTH        = 2,
    parameter int AR_DEPTH        = 2,
    parameter int B_DEPTH         = 2,
    parameter int W_DEPTH         = 4,
    parameter int R_DEPTH         = 4,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        s_awvalid,
    output logic                        s_awready,
    input  logic [AXI_ID_WIDTH-1:0]     s_awid,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_awaddr,
    input  logic [7:0]                  s_awlen,
    input  logic [2:0]                  s_awsize,
    input  logic [1:0]                  s_awburst,
    input  logic                        s_awlock,
    input  logic [3:0]                  s_awcache,
    input  logic [2:0]                  s_awprot,
    input  logic [3:0]                  s_awqos,
    input  logic [3:0]                  s_awregion,
    input  logic [AXI_USER_WIDTH-1:0]   s_awuser,
    input  logic                        s_wvalid,
    output logic                        s_wready,
    input  logic [AXI_DATA_WIDTH-1:0]   s_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                        s_wlast,
    input  logic [AXI_USER_WIDTH-1:0]   s_wuser,
    output logic                        s_bvalid,
    input  logic                        s_bready,
    output logic [AXI_ID_WIDTH-1:0]     s_bid,
    output logic [1:0]                  s_bresp,
    output logic [AXI_USER_WIDTH-1:0]   s_buser,
    input  logic                        s_arvalid,
    output logic                        s_arready,
    input  logic [AXI_ID_WIDTH-1:0]     s_arid,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_araddr,
    input  logic [7:0]                  s_arlen,
    input  logic [2:0]                  s_arsize,
    input  logic [1:0]                  s_arburst,
    input  logic                        s_arlock,
    input  logic [3:0]                  s_arcache,
    input  logic [2:0]                  s_arprot,
    input  logic [3:0]                  s_arqos,
    input  logic [3:0]                  s_arregion,
    input  logic [AXI_USER_WIDTH-1:0]   s_aruser,
    output logic                        s_rvalid,
    input  logic                        s_rready,
    output logic [AXI_ID_WIDTH-1:0]     s_rid,
    output logic [AXI_DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]                  s_rresp,
    output logic                        s_rlast,
    output logic [AXI_USER_WIDTH-1:0]   s_ruser,
    output logic                        m_awvalid,
    input  logic                        m_awready,
    output logic [AXI_ID_WIDTH-1:0]     m_awid,
    output logic [AXI_ADDR_WIDTH-1:0]   m_awaddr,
    output logic [7:0]                  m_awlen,
    output logic [2:0]                  m_awsize,
    output logic [1:0]                  m_awburst,
    output logic                        m_awlock,
    output logic [3:0]                  m_awcache,
    output logic [2:0]                  m_awprot,
    output logic [3:0]                  m_awqos,
    output logic [3:0]                  m_awregion,
    output logic [AXI_USER_WIDTH-1:0]   m_awuser,
    output logic                        m_wvalid,
    input  logic                        m_wready,
    output logic [AXI_DATA_WIDTH-1:0]   m_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] m_wstrb,
    output logic                        m_wlast,
    output logic [AXI_USER_WIDTH-1:0]   m_wuser,
    input  logic                        m_bvalid,
    output logic                        m_bready,
    input  logic [AXI_ID_WIDTH-1:0]     m_bid,
    input  logic [1:0]                  m_bresp,
    input  logic [AXI_USER_WIDTH-1:0]   m_buser,
    output logic                        m_arvalid,
    input  logic                        m_arready,
    output logic [AXI_ID_WIDTH-1:0]     m_arid,
    output logic [AXI_ADDR_WIDTH-1:0]   m_araddr,
    output logic [7:0]                  m_arlen,
    output logic [2:0]                  m_arsize,
    output logic [1:0]                  m_arburst,
    output logic                        m_arlock,
    output logic [3:0]                  m_arcache,
    output logic [2:0]                  m_arprot,
    output logic [3:0]                  m_arqos,
    output logic [3:0]                  m_arregion,
    output logic [AXI_USER_WIDTH-1:0]   m_aruser,
    input  logic                        m_rvalid,
    output logic                        m_rready,
    input  logic [AXI_ID_WIDTH-1:0]     m_rid,
    input  logic [AXI_DATA_WIDTH-1:0]   m_rdata,
    input  logic [1:0]                  m_rresp,
    input  logic                        m_rlast,
    input  logic [AXI_USER_WIDTH-1:0]   m_ruser,
    input  logic                        isolate_i,
    output logic                        isolated_o,
    output logic                        incoming_req_o
);
    localparam int AW_W = AXI_ID_WIDTH + AXI_ADDR_WIDTH + AXI_USER_WIDTH + 29;
    localparam int W_W  = AXI_DATA_WIDTH + AXI_DATA_WIDTH / 8 + 1 + AXI_USER_WIDTH;
    localparam int B_W  = AXI_ID_WIDTH + 2 + AXI_USER_WIDTH;
    localparam int R_W  = AXI_ID_WIDTH + AXI_DATA_WIDTH + 3 + AXI_USER_WIDTH;
    localparam int CW   = $clog2(MAX_OUTSTANDING + 1);
    typedef enum logic [1:0] {RUN, DRAIN, ISOLATED} state_t;
    state_t state, state_nxt;
    logic [CW-1:0] wcnt, rcnt;
    logic [AW_W-1:0] aw_rdata, ar_rdata;
    logic [W_W-1:0] w_rdata;
    logic [B_W-1:0] b_rdata;
    logic [R_W-1:0] r_rdata;
    logic aw_full, aw_empty, w_full, w_empty, b_full, b_empty, ar_full, ar_empty, r_full, r_empty;
    logic aw_push, w_push, b_push, ar_push, r_push, aw_pop, w_pop, b_pop, ar_pop, r_pop;
    logic drained, iso;
    assign iso = state == ISOLATED;
    // Readies depend only on local state, never on the opposite side's ready.
    assign s_awready = !aw_full && state == RUN && wcnt != CW'(MAX_OUTSTANDING);
    assign s_arready = !ar_full && state == RUN && rcnt != CW'(MAX_OUTSTANDING);
    assign s_wready  = !w_full && !iso;
    assign m_bready  = !b_full;
    assign m_rready  = !r_full;
    assign m_awvalid = !aw_empty && !iso;
    assign m_wvalid  = !w_empty && !iso;
    assign m_arvalid = !ar_empty && !iso;
    assign s_bvalid  = !b_empty;
    assign s_rvalid  = !r_empty;
    assign aw_push = s_awvalid && s_awready;
    assign w_push  = s_wvalid && s_wready;
    assign ar_push = s_arvalid && s_arready;
    assign b_push  = m_bvalid && m_bready;
    assign r_push  = m_rvalid && m_rready;
    assign aw_pop  = m_awvalid && m_awready;
    assign w_pop   = m_wvalid && m_wready;
    assign ar_pop  = m_arvalid && m_arready;
    assign b_pop   = s_bvalid && s_bready;
    assign r_pop   = s_rvalid && s_rready;
    assign drained = wcnt == '0 && rcnt == '0 && aw_empty && w_empty && b_empty && ar_empty && r_empty;
    assign isolated_o     = iso;
    assign incoming_req_o = iso && (s_awvalid || s_arvalid || s_wvalid);
    assign {m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awlock, m_awcache, m_awprot, m_awqos, m_awregion, m_awuser} = aw_rdata;
    assign {m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arlock, m_arcache, m_arprot, m_arqos, m_arregion, m_aruser} = ar_rdata;
    assign {m_wdata, m_wstrb, m_wlast, m_wuser} = w_rdata;
    assign {s_bid, s_bresp, s_buser} = b_rdata;
    assign {s_rid, s_rdata, s_rresp, s_rlast, s_ruser} = r_rdata;
    // Dropping isolate_i always wins, even over completing a drain.
    always_comb begin
        state_nxt = !isolate_i ? RUN : state == RUN ? DRAIN : (state == DRAIN && drained) ? ISOLATED : state;
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= RUN;
            wcnt  <= '0;
            rcnt  <= '0;
        end else begin
            state <= state_nxt;
            if (aw_push != b_pop) wcnt <= aw_push ? wcnt + 1'b1 : wcnt - 1'b1;
            if (ar_push != (r_pop && s_rlast)) rcnt <= ar_push ? rcnt + 1'b1 : rcnt - 1'b1;
        end
    end
    axi_slice_iso_fifo #(.W(AW_W), .DEPTH(AW_DEPTH)) u_aw (
        .clk(clk_i), .rst(rst_i), .push(aw_push), .pop(aw_pop),
        .wdata({s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awlock, s_awcache, s_awprot, s_awqos, s_awregion, s_awuser}),
        .rdata(aw_rdata), .full(aw_full), .empty(aw_empty)
    );
    axi_slice_iso_fifo #(.W(W_W), .DEPTH(W_DEPTH)) u_w (
        .clk(clk_i), .rst(rst_i), .push(w_push), .pop(w_pop),
        .wdata({s_wdata, s_wstrb, s_wlast, s_wuser}),
        .rdata(w_rdata), .full(w_full), .empty(w_empty)
    );
    axi_slice_iso_fifo #(.W(B_W), .DEPTH(B_DEPTH)) u_b (
        .clk(clk_i), .rst(rst_i), .push(b_push), .pop(b_pop),
        .wdata({m_bid, m_bresp, m_buser}),
        .rdata(b_rdata), .full(b_full), .empty(b_empty)
    );
    axi_slice_iso_fifo #(.W(AW_W), .DEPTH(AR_DEPTH)) u_ar (
        .clk(clk_i), .rst(rst_i), .push(ar_push), .pop(ar_pop),
        .wdata({s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arlock, s_arcache, s_arprot, s_arqos, s_arregion, s_aruser}),
        .rdata(ar_rdata), .full(ar_full), .empty(ar_empty)
    );
    axi_slice_iso_fifo #(.W(R_W), .DEPTH(R_DEPTH)) u_r (
        .clk(clk_i), .rst(rst_i), .push(r_push), .pop(r_pop),
        .wdata({m_rid, m_rdata, m_rresp, m_rlast, m_ruser}),
        .rdata(r_rdata), .full(r_full), .empty(r_empty)
    );
endmodule

// File: tb/tb_axi_slice_iso.sv
// tb_axi_slice_iso: randomized scoreboard bench for axi_slice_iso against a queue-level model.
module tb_axi_slice_iso;
    localparam int AW = 32, DW = 64, UW = 6, IW = 6;
    localparam int AWD = 2, ARD = 2, BD = 2, WD = 4, RD = 4, MO = 8;
    localparam int AWW = IW + AW + UW + 29, WW = DW + DW / 8 + 1 + UW, BW = IW + 2 + UW, RW = IW + DW + 3 + UW;
    localparam int RUN = 0, DRAIN = 1, ISO = 2;
    logic clk, rst, isolate_i, isolated_o, incoming_req_o;
    logic s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
    logic m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;
    logic [IW-1:0] s_awid, m_awid, s_arid, m_arid, s_bid, m_bid, s_rid, m_rid;
    logic [AW-1:0] s_awaddr, m_awaddr, s_araddr, m_araddr;
    logic [7:0] s_awlen, m_awlen, s_arlen, m_arlen;
    logic [2:0] s_awsize, m_awsize, s_arsize, m_arsize, s_awprot, m_awprot, s_arprot, m_arprot;
    logic [1:0] s_awburst, m_awburst, s_arburst, m_arburst, s_bresp, m_bresp, s_rresp, m_rresp;
    logic s_awlock, m_awlock, s_arlock, m_arlock, s_wlast, m_wlast, s_rlast, m_rlast;
    logic [3:0] s_awcache, m_awcache, s_arcache, m_arcache, s_awqos, m_awqos, s_arqos, m_arqos;
    logic [3:0] s_awregion, m_awregion, s_arregion, m_arregion;
    logic [UW-1:0] s_awuser, m_awuser, s_aruser, m_aruser, s_wuser, m_wuser, s_buser, m_buser, s_ruser, m_ruser;
    logic [DW-1:0] s_wdata, m_wdata, s_rdata, m_rdata;
    logic [DW/8-1:0] s_wstrb, m_wstrb;
    logic [AWW-1:0] saw_pl, maw_pl, sar_pl, mar_pl;
    logic [WW-1:0] sw_pl, mw_pl;
    logic [BW-1:0] mb_pl, sb_pl;
    logic [RW-2:0] mr_pl;
    logic [RW-1:0] mr_full, sr_full;
    assign {s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awlock, s_awcache, s_awprot, s_awqos, s_awregion, s_awuser} = saw_pl;
    assign {s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arlock, s_arcache, s_arprot, s_arqos, s_arregion, s_aruser} = sar_pl;
    assign {s_wdata, s_wstrb, s_wlast, s_wuser} = sw_pl;
    assign {m_bid, m_bresp, m_buser} = mb_pl;
    assign {m_rid, m_rdata, m_rresp, m_ruser} = mr_pl;
    assign maw_pl = {m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awlock, m_awcache, m_awprot, m_awqos, m_awregion, m_awuser};
    assign mar_pl = {m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arlock, m_arcache, m_arprot, m_arqos, m_arregion, m_aruser};
    assign mw_pl = {m_wdata, m_wstrb, m_wlast, m_wuser};
    assign sb_pl = {s_bid, s_bresp, s_buser};
    assign mr_full = {m_rid, m_rdata, m_rresp, m_rlast, m_ruser};
    assign sr_full = {s_rid, s_rdata, s_rresp, s_rlast, s_ruser};

    axi_slice_iso #(
        .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_USER_WIDTH(UW), .AXI_ID_WIDTH(IW),
        .AW_DEPTH(AWD), .AR_DEPTH(ARD), .B_DEPTH(BD), .W_DEPTH(WD), .R_DEPTH(RD), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
        .s_awsize(s_awsize), .s_awburst(s_awburst), .s_awlock(s_awlock), .s_awcache(s_awcache), .s_awprot(s_awprot),
        .s_awqos(s_awqos), .s_awregion(s_awregion), .s_awuser(s_awuser),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wuser(s_wuser),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp), .s_buser(s_buser),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen),
        .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arlock(s_arlock), .s_arcache(s_arcache), .s_arprot(s_arprot),
        .s_arqos(s_arqos), .s_arregion(s_arregion), .s_aruser(s_aruser),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_ruser(s_ruser),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
        .m_awsize(m_awsize), .m_awburst(m_awburst), .m_awlock(m_awlock), .m_awcache(m_awcache), .m_awprot(m_awprot),
        .m_awqos(m_awqos), .m_awregion(m_awregion), .m_awuser(m_awuser),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wuser(m_wuser),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bresp(m_bresp), .m_buser(m_buser),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arcache(m_arcache), .m_arprot(m_arprot),
        .m_arqos(m_arqos), .m_arregion(m_arregion), .m_aruser(m_aruser),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_ruser(m_ruser),
        .isolate_i(isolate_i), .isolated_o(isolated_o), .incoming_req_o(incoming_req_o)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Reference model: queue per channel holds exactly what the slice should be buffering.
    logic [AWW-1:0] aw_q[$], ar_q[$];
    logic [WW-1:0] w_q[$];
    logic [BW-1:0] b_q[$];
    logic [RW-1:0] r_q[$];
    int st, wcnt, rcnt, pend_b, pend_r, r_left;
    int checks = 0, failures = 0;
    int p_aw, p_rdy, p_b, p_iso;
    bit f_saw, f_sw, f_sar, f_mb, f_mr, f_maw, f_mw, f_mar, f_sb, f_sr;
    bit e_awr, e_wr, e_arr, e_mbr, e_mrr, e_maw, e_mw, e_mar, e_sb, e_sr, drained;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic bit pr(input int p);
        return $urandom_range(99, 0) < p;
    endfunction

    // Monitor: checks the cycle's outputs, then advances the model for the coming edge.
    always @(negedge clk) begin
        if (!rst) begin
            e_awr = aw_q.size() < AWD && st == RUN && wcnt < MO;
            e_arr = ar_q.size() < ARD && st == RUN && rcnt < MO;
            e_wr  = w_q.size() < WD && st != ISO;
            e_mbr = b_q.size() < BD;
            e_mrr = r_q.size() < RD;
            e_maw = aw_q.size() > 0 && st != ISO;
            e_mw  = w_q.size() > 0 && st != ISO;
            e_mar = ar_q.size() > 0 && st != ISO;
            e_sb  = b_q.size() > 0;
            e_sr  = r_q.size() > 0;
            chk("s_awready", s_awready, e_awr);
            chk("s_wready", s_wready, e_wr);
            chk("s_arready", s_arready, e_arr);
            chk("m_bready", m_bready, e_mbr);
            chk("m_rready", m_rready, e_mrr);
            chk("m_awvalid", m_awvalid, e_maw);
            chk("m_wvalid", m_wvalid, e_mw);
            chk("m_arvalid", m_arvalid, e_mar);
            chk("s_bvalid", s_bvalid, e_sb);
            chk("s_rvalid", s_rvalid, e_sr);
            chk("isolated_o", isolated_o, st == ISO);
            chk("incoming_req_o", incoming_req_o, st == ISO && (s_awvalid || s_arvalid || s_wvalid));
            if (e_maw) chk("aw_payload", maw_pl, aw_q[0]);
            if (e_mw) chk("w_payload", mw_pl, w_q[0]);
            if (e_mar) chk("ar_payload", mar_pl, ar_q[0]);
            if (e_sb) chk("b_payload", sb_pl, b_q[0]);
            if (e_sr) chk("r_payload", sr_full, r_q[0]);
            drained = wcnt == 0 && rcnt == 0 && aw_q.size() == 0 && w_q.size() == 0 && ar_q.size() == 0
                      && b_q.size() == 0 && r_q.size() == 0;
            f_saw = s_awvalid && e_awr;
            f_sw  = s_wvalid && e_wr;
            f_sar = s_arvalid && e_arr;
            f_mb  = m_bvalid && e_mbr;
            f_mr  = m_rvalid && e_mrr;
            f_maw = e_maw && m_awready;
            f_mw  = e_mw && m_wready;
            f_mar = e_mar && m_arready;
            f_sb  = e_sb && s_bready;
            f_sr  = e_sr && s_rready;
            if (!isolate_i) st = RUN;
            else if (st == RUN) st = DRAIN;
            else if (st == DRAIN && drained) st = ISO;
            wcnt = wcnt + int'(f_saw) - int'(f_sb);
            rcnt = rcnt + int'(f_sar) - int'(f_sr && r_q[0][UW]);
            if (f_maw) void'(aw_q.pop_front());
            if (f_mw) void'(w_q.pop_front());
            if (f_mar) void'(ar_q.pop_front());
            if (f_sb) void'(b_q.pop_front());
            if (f_sr) void'(r_q.pop_front());
        end
    end

    // Driver: records accepted stimulus into the scoreboard, then offers the next beats.
    task automatic step();
        if (f_saw) aw_q.push_back(saw_pl);
        if (f_sw) w_q.push_back(sw_pl);
        if (f_sar) ar_q.push_back(sar_pl);
        if (f_mb) b_q.push_back(mb_pl);
        if (f_mr) r_q.push_back(mr_full);
        pend_b += int'(f_maw);
        pend_r += int'(f_mar);
        if (!s_awvalid || f_saw) begin
            s_awvalid = pr(p_aw);
            saw_pl = AWW'(rnd128());
        end
        if (!s_wvalid || f_sw) begin
            s_wvalid = pr(p_aw);
            sw_pl = WW'(rnd128());
        end
        if (!s_arvalid || f_sar) begin
            s_arvalid = pr(p_aw);
            sar_pl = AWW'(rnd128());
        end
        m_awready = pr(p_rdy);
        m_wready = pr(p_rdy);
        m_arready = pr(p_rdy);
        s_bready = pr(p_rdy);
        s_rready = pr(p_rdy);
        if (!m_bvalid || f_mb) begin
            m_bvalid = pend_b > 0 && pr(p_b);
            if (m_bvalid) begin
                pend_b--;
                mb_pl = BW'(rnd128());
            end
        end
        if (!m_rvalid || f_mr) begin
            if (r_left == 0 && pend_r > 0 && pr(p_b)) begin
                r_left = $urandom_range(3, 1);
                pend_r--;
            end
            m_rvalid = r_left > 0 && pr(p_b);
            if (m_rvalid) begin
                mr_pl = (RW-1)'(rnd128());
                m_rlast = r_left == 1;
                r_left--;
            end
        end
        if (p_iso == 0) isolate_i = 0;
        else if (pr(p_iso)) isolate_i = !isolate_i;
    endtask

    task automatic clear_model();
        aw_q.delete(); w_q.delete(); ar_q.delete(); b_q.delete(); r_q.delete();
        st = RUN; wcnt = 0; rcnt = 0; pend_b = 0; pend_r = 0; r_left = 0;
        {f_saw, f_sw, f_sar, f_mb, f_mr, f_maw, f_mw, f_mar, f_sb, f_sr} = '0;
        {s_awvalid, s_wvalid, s_arvalid, m_bvalid, m_rvalid} = '0;
    endtask

    task automatic check_reset_outs(input string nm);
        chk(nm, {s_awready, s_wready, s_arready, m_bready, m_rready, m_awvalid, m_wvalid, m_arvalid,
                 s_bvalid, s_rvalid, isolated_o, incoming_req_o}, 12'b1111_1000_0000);
    endtask

    // Asynchronous reset mid-cycle: outputs must reach reset values before the next edge.
    task automatic mid_reset();
        @(posedge clk);
        #3;
        rst = 1;
        clear_model();
        #1;
        check_reset_outs("mid_reset_outs");
        isolate_i = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
    endtask

    initial begin
        rst = 1;
        isolate_i = 0;
        saw_pl = '0; sar_pl = '0; sw_pl = '0; mb_pl = '0; mr_pl = '0; m_rlast = 0;
        {m_awready, m_wready, m_arready, s_bready, s_rready} = '0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outs("reset_outs");
        rst = 0;
        for (int ph = 0; ph < 6; ph++) begin
            case (ph)
                0: begin p_aw = 70; p_rdy = 80; p_b = 60; p_iso = 0; end
                1: begin p_aw = 90; p_rdy = 90; p_b = 5;  p_iso = 0; end
                2: begin p_aw = 60; p_rdy = 50; p_b = 50; p_iso = 3; end
                3: begin p_aw = 30; p_rdy = 90; p_b = 80; p_iso = 2; end
                4: begin p_aw = 90; p_rdy = 30; p_b = 30; p_iso = 1; end
                default: begin p_aw = 50; p_rdy = 70; p_b = 70; p_iso = 4; end
            endcase
            for (int c = 0; c < 400; c++) begin
                @(posedge clk);
                #1;
                step();
            end
            if (ph == 2 || ph == 4) mid_reset();
        end
        p_iso = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            step();
        end
        @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
